regfile_mp: RTL and testbench

//   Parametrised multi-read-port register file for the multicycle CPU datapath.

---
 rtl/regfile_mp_if.sv | 30 +++
 rtl/regfile_mp.sv | 95 +++++++++
 tb/tb_regfile_mp.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Register-file access bundle: decode-side read ports, writeback port,
// destination reservation and the clear-sweep handshake.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    localparam int NREGS = 2 ** ADDR_W;

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic [NREGS-1:0]         busy;
    logic                     clr_req;
    logic                     clr_busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
        input  rd_data, busy, clr_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
        output rd_data, busy, clr_busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional write-to-read bypass,
// pending-write scoreboard and a hardware clear sweep.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input logic          clk,
    input logic          rst_n,
    regfile_mp_if.slave  bus
);
    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_LAST  = '1;

    typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_W-1:0]       r_idx;
    logic [DATA_W-1:0]       r_regs [NREGS];
    logic [NREGS-1:0]        r_busy;
    logic                    w_idle;
    logic                    w_wr_ok;
    logic                    w_rsv_ok;
    logic                    w_sweep_last;
    logic [NUM_RD*DATA_W-1:0] w_rd_data;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_wr_ok      = w_idle && bus.wr_en && (bus.wr_addr != '0);
    assign w_rsv_ok     = w_idle && bus.rsv_en && (bus.rsv_addr != '0);
    assign w_sweep_last = (r_idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.clr_req) w_state_nxt = ST_SWEEP;
            ST_SWEEP: if (w_sweep_last) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= IDX_FIRST;
            r_busy <= '0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_idle) begin
            r_idx <= IDX_FIRST;
            if (w_wr_ok) begin
                r_regs[bus.wr_addr] <= bus.wr_data;
            end
            if (bus.clr_req) begin
                r_busy <= '0;
            end else begin
                // Reservation is applied after the clear so a same-address set wins.
                if (w_wr_ok) r_busy[bus.wr_addr] <= 1'b0;
                if (w_rsv_ok) r_busy[bus.rsv_addr] <= 1'b1;
            end
        end else begin
            r_regs[r_idx] <= '0;
            r_idx         <= w_sweep_last ? IDX_FIRST : r_idx + IDX_FIRST;
        end
    end

    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (bus.rd_addr[k*ADDR_W +: ADDR_W] == '0) begin
                w_rd_data[k*DATA_W +: DATA_W] = '0;
            end else if ((BYPASS != 0) && w_wr_ok &&
                         (bus.wr_addr == bus.rd_addr[k*ADDR_W +: ADDR_W])) begin
                w_rd_data[k*DATA_W +: DATA_W] = bus.wr_data;
            end else begin
                w_rd_data[k*DATA_W +: DATA_W] = r_regs[bus.rd_addr[k*ADDR_W +: ADDR_W]];
            end
        end
    end

    assign bus.rd_data  = w_rd_data;
    assign bus.busy     = r_busy;
    assign bus.clr_busy = (r_state == ST_SWEEP);
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypass and a non-bypass instance share the same
// stimulus and are compared against a behavioural register-file model.
module tb_regfile_mp;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int NREGS  = 2 ** ADDR_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) if1 ();
    regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) if0 ();

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .BYPASS(1)) u_dut_byp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .BYPASS(0)) u_dut_nobyp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    assign if0.rd_addr  = if1.rd_addr;
    assign if0.wr_en    = if1.wr_en;
    assign if0.wr_addr  = if1.wr_addr;
    assign if0.wr_data  = if1.wr_data;
    assign if0.rsv_en   = if1.rsv_en;
    assign if0.rsv_addr = if1.rsv_addr;
    assign if0.clr_req  = if1.clr_req;

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_clr_hi = 0;

    logic [DATA_W-1:0] m_regs [NREGS];
    logic [NREGS-1:0]  m_busy;
    bit                m_sweep;
    int                m_pos;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_busy  = '0;
        m_sweep = 0;
        m_pos   = 1;
    endtask

    function automatic logic [DATA_W-1:0] exp_read(input int addr, input bit byp);
        if (addr == 0) return '0;
        if (byp && !m_sweep && if1.wr_en && (int'(if1.wr_addr) == addr)) return if1.wr_data;
        return m_regs[addr];
    endfunction

    task automatic model_edge();
        if (!m_sweep) begin
            if (if1.wr_en && if1.wr_addr != 0) m_regs[if1.wr_addr] = if1.wr_data;
            if (if1.clr_req) begin
                m_busy  = '0;
                m_sweep = 1;
                m_pos   = 1;
            end else begin
                if (if1.wr_en && if1.wr_addr != 0) m_busy[if1.wr_addr] = 1'b0;
                if (if1.rsv_en && if1.rsv_addr != 0) m_busy[if1.rsv_addr] = 1'b1;
            end
        end else begin
            m_regs[m_pos] = '0;
            m_pos++;
            if (m_pos == NREGS) m_sweep = 0;
        end
    endtask

    task automatic check_outputs();
        int a;
        for (int k = 0; k < NUM_RD; k++) begin
            a = int'(if1.rd_addr[k*ADDR_W +: ADDR_W]);
            chk($sformatf("rd_byp p%0d a%0d", k, a), 64'(if1.rd_data[k*DATA_W +: DATA_W]), 64'(exp_read(a, 1)));
            chk($sformatf("rd_nobyp p%0d a%0d", k, a), 64'(if0.rd_data[k*DATA_W +: DATA_W]), 64'(exp_read(a, 0)));
        end
        chk("busy_byp", 64'(if1.busy), 64'(m_busy));
        chk("busy_nobyp", 64'(if0.busy), 64'(m_busy));
        chk("clr_busy_byp", 64'(if1.clr_busy), 64'(m_sweep));
        chk("clr_busy_nobyp", 64'(if0.clr_busy), 64'(m_sweep));
        if (if1.clr_busy) n_clr_hi++;
    endtask

    task automatic set_rd(input int a0, input int a1);
        if1.rd_addr[0 +: ADDR_W]      = ADDR_W'(a0);
        if1.rd_addr[ADDR_W +: ADDR_W] = ADDR_W'(a1);
    endtask

    task automatic set_wr(input bit en, input int addr, input logic [DATA_W-1:0] data);
        if1.wr_en   = en;
        if1.wr_addr = ADDR_W'(addr);
        if1.wr_data = data;
    endtask

    task automatic set_rsv(input bit en, input int addr);
        if1.rsv_en   = en;
        if1.rsv_addr = ADDR_W'(addr);
    endtask

    task automatic idle_inputs();
        set_wr(0, 0, '0);
        set_rsv(0, 0);
        if1.clr_req = 1'b0;
    endtask

    // One clock: check combinational outputs, then advance model with the edge.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic read_all();
        idle_inputs();
        for (int a = 0; a < NREGS; a++) begin
            set_rd(a, NREGS - 1 - a);
            step();
        end
    endtask

    task automatic random_inputs(input bit allow_clr);
        set_rd($urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1));
        set_wr($urandom_range(0, 1), $urandom_range(0, NREGS - 1), $urandom);
        set_rsv($urandom_range(0, 2) == 0, $urandom_range(0, NREGS - 1));
        if1.clr_req = allow_clr;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        set_rd(0, 0);

        // Reset held: all registers read zero on both ports.
        for (int a = 0; a < NREGS; a++) begin
            set_rd(a, a);
            #1;
            check_outputs();
        end
        @(negedge clk);
        rst_n = 1'b1;
        read_all();

        // Same-cycle bypass, then array read on both ports.
        set_wr(1, 5, 32'hDEADBEEF);
        set_rd(5, 5);
        step();
        idle_inputs();
        set_rd(5, 5);
        step();

        // Register 0 is immune to writes and reservations.
        set_wr(1, 0, 32'h1234);
        set_rsv(1, 0);
        set_rd(0, 0);
        step();
        idle_inputs();
        step();

        // Scoreboard set / simultaneous set+clear / clear.
        set_rsv(1, 7);
        set_rd(7, 5);
        step();
        set_wr(1, 7, 32'h0000_0077);
        set_rsv(1, 7);
        step();
        set_rsv(0, 0);
        set_wr(1, 7, 32'h0000_0777);
        step();
        idle_inputs();
        step();
        chk("busy7_clear", 64'(if1.busy[7]), 64'd0);

        // Fill, sweep with ignored traffic, then verify everything is zero.
        for (int i = 1; i < NREGS; i++) begin
            set_wr(1, i, DATA_W'(i));
            set_rsv(1, (i % 7) + 1);
            set_rd(i, i - 1);
            step();
        end
        idle_inputs();
        set_rsv(1, 3);
        step();
        idle_inputs();
        if1.clr_req = 1'b1;
        set_wr(1, 9, 32'hCAFE_0009);
        n_clr_hi = 0;
        step();
        for (int c = 0; c < NREGS - 1; c++) begin
            random_inputs($urandom_range(0, 1));
            step();
        end
        read_all();
        chk("sweep_len", 64'(n_clr_hi), 64'(NREGS - 1));
        chk("busy_after_sweep", 64'(if1.busy), 64'd0);

        // Reset during a sweep aborts it immediately.
        for (int i = 1; i < NREGS; i++) begin
            set_wr(1, i, $urandom);
            set_rd(i, i);
            step();
        end
        idle_inputs();
        if1.clr_req = 1'b1;
        step();
        idle_inputs();
        for (int c = 0; c < 10; c++) begin
            set_rd(20 + (c % 10), 30);
            step();
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        for (int a = 0; a < NREGS; a++) begin
            set_rd(a, NREGS - 1 - a);
            #1;
            check_outputs();
        end
        @(negedge clk);
        rst_n = 1'b1;
        read_all();

        // Randomised traffic with occasional clear sweeps.
        for (int c = 0; c < 400; c++) begin
            random_inputs($urandom_range(0, 39) == 0);
            step();
        end
        read_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
